alu_op_dispatch: RTL and testbench

- Upstream command stage for the 8-bit ALU arithmetic units: adder, subtractor, restoring divider and radix-4 multiplier.
- Accepts one operation (opcode plus two 8-bit operands) over a valid/ready handshake, registers the operands and drives them to the units.
- Pulses the start of the multi-cycle units and waits for their done.
- Captures the selected unit's result and flags into a holding register, then presents it downstream with a valid/ready handshake.

---
 rtl/alu_op_dispatch_if.sv | 24 ++
 rtl/alu_op_dispatch.sv | 170 +++++++++++++++++
 tb/tb_alu_op_dispatch.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_dispatch_if.sv
// rtl/alu_op_dispatch_if.sv - command and result handshake bundle for alu_op_dispatch
interface alu_op_dispatch_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  flags;

    // master: the environment issuing commands and consuming results
    modport master (
        output in_valid, op, x, y, out_ready,
        input  in_ready, out_valid, result, flags
    );

    // slave: the dispatch block itself
    modport slave (
        input  in_valid, op, x, y, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/alu_op_dispatch.sv
// rtl/alu_op_dispatch.sv - ALU command dispatch to add/sub/mul/div units (optional WAIT timeout via ALU_TIMEOUT_EN)
module alu_op_dispatch #(
    parameter int TIMEOUT_CYC = 32,
    parameter int SETTLE_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    alu_op_dispatch_if.slave bus,
    output logic [7:0]       opnd_x,
    output logic [7:0]       opnd_y,
    input  logic [7:0]       add_z,
    input  logic             add_cout,
    input  logic             add_ovr,
    input  logic [7:0]       sub_b,
    input  logic             sub_bout,
    output logic             mul_start,
    input  logic             mul_done,
    input  logic [15:0]      mul_res,
    output logic             div_start,
    input  logic             div_done,
    input  logic [7:0]       div_cat,
    input  logic [7:0]       div_rest
);
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
    // one counter serves both the add/sub settle countdown and the mul/div timeout count
    localparam int CMAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     opnd_x_d, opnd_y_d;
    logic           mul_start_d, div_start_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [15:0]    result_q, result_d;
    logic [3:0]     flags_q, flags_d;
    logic           capture;
    logic           timeout;
    logic           div_zero;

    assign div_zero      = (op_q == OP_DIV) && (opnd_y == 8'h00);
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

    // state and all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            cnt_q       <= '0;
            opnd_x      <= 8'h00;
            opnd_y      <= 8'h00;
            mul_start   <= 1'b0;
            div_start   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= 16'h0000;
            flags_q     <= 4'h0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            opnd_x      <= opnd_x_d;
            opnd_y      <= opnd_y_d;
            mul_start   <= mul_start_d;
            div_start   <= div_start_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    // next state: only the done of the unit matching the latched op is looked at
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE:  if (bus.in_valid) state_d = ISSUE;
            ISSUE: state_d = div_zero ? RESP : WAIT;
            WAIT: begin
                case (op_q)
                    OP_MUL:  capture = mul_done;
                    OP_DIV:  capture = div_done;
                    default: capture = (cnt_q == '0);
                endcase
`ifdef ALU_TIMEOUT_EN
                // a done on the expiry cycle takes priority over the timeout
                timeout = !capture && op_q[1] && (cnt_q == CW'(TIMEOUT_CYC - 1));
`endif
                if (capture || timeout) state_d = RESP;
            end
            RESP:  if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // next values of the registered outputs
    always_comb begin
        op_d        = op_q;
        cnt_d       = cnt_q;
        opnd_x_d    = opnd_x;
        opnd_y_d    = opnd_y;
        mul_start_d = 1'b0;
        div_start_d = 1'b0;
        result_d    = result_q;
        flags_d     = flags_q;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == RESP);
        case (state_q)
            IDLE: if (bus.in_valid) begin
                op_d        = bus.op;
                opnd_x_d    = bus.x;
                opnd_y_d    = bus.y;
                // start is registered so it is high exactly during the ISSUE cycle
                mul_start_d = (bus.op == OP_MUL);
                div_start_d = (bus.op == OP_DIV) && (bus.y != 8'h00);
            end
            ISSUE: begin
                cnt_d = op_q[1] ? '0 : CW'(SETTLE_CYC - 1);
                if (div_zero) begin
                    result_d = {8'hFF, opnd_x};
                    flags_d  = 4'b0100;
                end
            end
            WAIT: begin
                if (capture) begin
                    case (op_q)
                        OP_ADD: begin
                            result_d = {8'h00, add_z};
                            flags_d  = {2'b00, add_ovr, add_cout};
                        end
                        OP_SUB: begin
                            result_d = {8'h00, sub_b};
                            flags_d  = {3'b000, sub_bout};
                        end
                        OP_MUL: begin
                            result_d = mul_res;
                            flags_d  = 4'h0;
                        end
                        default: begin
                            result_d = {div_cat, div_rest};
                            flags_d  = 4'h0;
                        end
                    endcase
                end else if (timeout) begin
                    result_d = 16'h0000;
                    flags_d  = 4'b1000;
                end else if (!op_q[1]) begin
                    cnt_d = cnt_q - 1'b1;
                end
`ifdef ALU_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_alu_op_dispatch.sv
// tb/tb_alu_op_dispatch.sv - self-checking bench for alu_op_dispatch with unit models and a reference model
module tb_alu_op_dispatch;
    localparam int TMO    = 8;
    localparam int SETTLE = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  opnd_x, opnd_y;
    logic [7:0]  add_z, sub_b;
    logic        add_cout, add_ovr, sub_bout;
    logic        mul_start, div_start;
    logic        mul_done_m = 1'b0, div_done_m = 1'b0;
    logic        mul_done, div_done;
    logic        mul_stray = 1'b0, div_stray = 1'b0;
    logic [15:0] mul_res = 16'h0;
    logic [7:0]  div_cat = 8'h0, div_rest = 8'h0;
    int          mul_lat = 5, div_lat = 3;
    int          mul_cnt = 0, div_cnt = 0;
    int          n_pass = 0, n_total = 0, n_fail = 0;

    alu_op_dispatch_if bus();

    alu_op_dispatch #(.TIMEOUT_CYC(TMO), .SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .opnd_x(opnd_x), .opnd_y(opnd_y),
        .add_z(add_z), .add_cout(add_cout), .add_ovr(add_ovr),
        .sub_b(sub_b), .sub_bout(sub_bout),
        .mul_start(mul_start), .mul_done(mul_done), .mul_res(mul_res),
        .div_start(div_start), .div_done(div_done),
        .div_cat(div_cat), .div_rest(div_rest)
    );

    always #5 clk = ~clk;

    // combinational adder / subtractor units
    assign {add_cout, add_z} = {1'b0, opnd_x} + {1'b0, opnd_y};
    assign add_ovr           = (opnd_x[7] == opnd_y[7]) && (add_z[7] != opnd_x[7]);
    assign {sub_bout, sub_b} = {1'b0, opnd_x} - {1'b0, opnd_y};
    assign mul_done          = mul_done_m | mul_stray;
    assign div_done          = div_done_m | div_stray;

    // multi-cycle units: done pulses <lat> cycles after the start cycle; lat 0 means never
    always @(posedge clk) begin
        if (mul_start && mul_lat > 0) begin
            mul_res    <= 16'(opnd_x) * 16'(opnd_y);
            mul_cnt    <= mul_lat - 1;
            mul_done_m <= (mul_lat == 1);
        end else if (mul_cnt > 0) begin
            mul_cnt    <= mul_cnt - 1;
            mul_done_m <= (mul_cnt == 1);
        end else begin
            mul_done_m <= 1'b0;
        end
        if (div_start && div_lat > 0 && opnd_y != 8'h00) begin
            div_cat    <= opnd_x / opnd_y;
            div_rest   <= opnd_x % opnd_y;
            div_cnt    <= div_lat - 1;
            div_done_m <= (div_lat == 1);
        end else if (div_cnt > 0) begin
            div_cnt    <= div_cnt - 1;
            div_done_m <= (div_cnt == 1);
        end else begin
            div_done_m <= 1'b0;
        end
    end

    // expected {flags, result} from the arithmetic meaning of each operation
    function automatic logic [19:0] ref_model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        int          ua, ub, sa, sb, s;
        logic [15:0] r;
        logic [3:0]  f;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        f  = 4'h0;
        case (o)
            2'd0: begin
                s    = ua + ub;
                r    = 16'(s % 256);
                f[0] = (s > 255);
                f[1] = (sa + sb > 127) || (sa + sb < -128);
            end
            2'd1: begin
                r    = 16'((ua - ub + 256) % 256);
                f[0] = (ua < ub);
            end
            2'd2: r = 16'(ua * ub);
            default: begin
                if (ub == 0) begin
                    r = 16'hFF00 + 16'(ua);
                    f = 4'b0100;
                end else begin
                    r = 16'((ua / ub) * 256 + (ua % ub));
                end
            end
        endcase
        return {f, r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one full transaction: accept, wait for result, hold out_ready low, then consume
    task automatic run_op(input string tag, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                          input int exp_lat, input int hold, input bit exp_timeout);
        logic [19:0] exp;
        logic [15:0] res0;
        logic [3:0]  flg0;
        int          lat, nmul, ndiv;
        bit          stable;
        exp = exp_timeout ? {4'b1000, 16'h0000} : ref_model(o, a, b);
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.x        = a;
        bus.y        = b;
        step();
        bus.in_valid = 1'b0;
        bus.x        = 8'($urandom);
        bus.y        = 8'($urandom);
        lat  = 1;
        nmul = int'(mul_start);
        ndiv = int'(div_start);
        while (!bus.out_valid && lat < 200) begin
            step();
            lat++;
            nmul += int'(mul_start);
            ndiv += int'(div_start);
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".mul_start_cycles"}, 32'(nmul), 32'(o == 2'd2));
        check({tag, ".div_start_cycles"}, 32'(ndiv), 32'((o == 2'd3) && (b != 8'h00)));
        check({tag, ".opnd"}, {16'h0, opnd_x, opnd_y}, {16'h0, a, b});
        res0   = bus.result;
        flg0   = bus.flags;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            step();
            if (bus.result !== res0 || bus.flags !== flg0 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                stable = 1'b0;
        end
        check({tag, ".hold_stable"}, 32'(stable), 32'd1);
        check({tag, ".result"}, 32'(bus.result), 32'(exp[15:0]));
        check({tag, ".flags"}, 32'(bus.flags), 32'(exp[19:16]));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, ".after_hs"}, {30'h0, bus.out_valid, bus.in_ready}, 32'b01);
        check({tag, ".result_kept"}, 32'(bus.result), 32'(exp[15:0]));
    endtask

    initial begin
        int          lat;
        logic [1:0]  o;
        logic [7:0]  a, b;
        bit          seen;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 2'b00;
        bus.x         = 8'h00;
        bus.y         = 8'h00;
        repeat (3) step();
        check("reset.hs", {30'h0, bus.in_ready, bus.out_valid}, 32'b10);
        check("reset.result", 32'(bus.result), 32'h0);
        check("reset.flags", 32'(bus.flags), 32'h0);
        check("reset.opnd", {16'h0, opnd_x, opnd_y}, 32'h0);
        check("reset.starts", {30'h0, mul_start, div_start}, 32'h0);
        rst = 1'b1;
        step();

        run_op("add", 2'd0, 8'h05, 8'h03, 2 + SETTLE, 0, 1'b0);
        run_op("sub", 2'd1, 8'h02, 8'h05, 2 + SETTLE, 5, 1'b0);
        mul_lat   = 5;
        div_stray = 1'b1;
        run_op("mul", 2'd2, 8'h07, 8'h06, 2 + 5, 1, 1'b0);
        div_stray = 1'b0;
        div_lat   = 4;
        run_op("div", 2'd3, 8'd17, 8'd5, 2 + 4, 0, 1'b0);
        run_op("div0", 2'd3, 8'h11, 8'h00, 2, 2, 1'b0);
        run_op("add_ovr", 2'd0, 8'h7F, 8'h01, 2 + SETTLE, 0, 1'b0);
        run_op("add_carry", 2'd0, 8'hFF, 8'h02, 2 + SETTLE, 0, 1'b0);

        // reset during WAIT abandons the operation, and the late done is ignored
        mul_lat      = 6;
        bus.in_valid = 1'b1;
        bus.op       = 2'd2;
        bus.x        = 8'h09;
        bus.y        = 8'h04;
        step();
        bus.in_valid = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        check("midrst.hs", {30'h0, bus.in_ready, bus.out_valid}, 32'b10);
        #1;
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        check("midrst.no_out_valid", 32'(seen), 32'd0);
        check("midrst.result", 32'(bus.result), 32'h0);

`ifdef ALU_TIMEOUT_EN
        mul_lat = 0;
        run_op("tmo", 2'd2, 8'h03, 8'h04, 2 + TMO, 0, 1'b1);
        mul_lat = TMO;
        run_op("tmo_edge", 2'd2, 8'h03, 8'h04, 2 + TMO, 0, 1'b0);
`else
        mul_lat = 4 * TMO;
        run_op("long_wait", 2'd2, 8'h0B, 8'h0D, 2 + 4 * TMO, 0, 1'b0);
`endif

        for (int n = 0; n < 24; n++) begin
            o         = 2'($urandom_range(0, 3));
            a         = 8'($urandom);
            b         = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            mul_lat   = $urandom_range(1, 6);
            div_lat   = $urandom_range(1, 6);
            mul_stray = (o == 2'd3) ? 1'($urandom) : 1'b0;
            div_stray = (o == 2'd2) ? 1'($urandom) : 1'b0;
            if (o[1] == 1'b0)
                lat = 2 + SETTLE;
            else if (o == 2'd3 && b == 8'h00)
                lat = 2;
            else
                lat = 2 + ((o == 2'd2) ? mul_lat : div_lat);
            run_op($sformatf("rand%0d", n), o, a, b, lat, $urandom_range(0, 3), 1'b0);
            mul_stray = 1'b0;
            div_stray = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
